// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions for the message-schedule block and, later, the
// round engine.
//   MSG_WORDS     : 32-bit words per 512-bit message block
//   ROUNDS        : schedule words emitted per block
//   sched_state_e : message-schedule FSM states
//   sha256_s0/s1  : small sigma functions used by the W recurrence
package sha256_pkg;

  localparam int unsigned MSG_WORDS = 16;
  localparam int unsigned ROUNDS    = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_EMIT,
    ST_DONE
  } sched_state_e;

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sha256_s0(input logic [31:0] x);
    return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sha256_s1(input logic [31:0] x);
    return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_w_schedule_if.sv
// Signal bundle between the message-schedule block and its surroundings
// (start request, message memory, K memory, W stream to the round engine).
//   master : the schedule block (sha256_w_schedule)
//   slave  : requester / memories / round engine side
// Signals:
//   start, msg_block                       request and block select
//   msg_mem_enable, msg_mem_address        message-memory read port
//   msg_mem_data                           message-memory read data (1-cycle latency)
//   kmem_enable, kmem_address              K-memory read port
//   w_out, w_valid, w_index                schedule word stream
//   busy, sched_done                       status
interface sha256_w_schedule_if #(
  parameter int unsigned MSG_ADDR_WIDTH  = 4,
  parameter int unsigned KMEM_ADDR_WIDTH = 6
) ();

  // A zero-width block select is not legal; with a 4-bit address the single
  // spare bit simply falls off the top of the address.
  localparam int unsigned BLK_WIDTH = (MSG_ADDR_WIDTH > 4) ? MSG_ADDR_WIDTH - 4 : 1;

  logic                       start;
  logic [BLK_WIDTH-1:0]       msg_block;
  logic                       msg_mem_enable;
  logic [MSG_ADDR_WIDTH-1:0]  msg_mem_address;
  logic [31:0]                msg_mem_data;
  logic                       kmem_enable;
  logic [KMEM_ADDR_WIDTH-1:0] kmem_address;
  logic [31:0]                w_out;
  logic                       w_valid;
  logic [5:0]                 w_index;
  logic                       busy;
  logic                       sched_done;

  modport master (
    input  start, msg_block, msg_mem_data,
    output msg_mem_enable, msg_mem_address,
    output kmem_enable, kmem_address,
    output w_out, w_valid, w_index, busy, sched_done
  );

  modport slave (
    output start, msg_block, msg_mem_data,
    input  msg_mem_enable, msg_mem_address,
    input  kmem_enable, kmem_address,
    input  w_out, w_valid, w_index, busy, sched_done
  );

endinterface

// File: rtl/sha256_sigma.sv
// Combinational SHA-256 small-sigma pair.
//   s0_in  -> s0_out = ROTR7 ^ ROTR18 ^ SHR3
//   s1_in  -> s1_out = ROTR17 ^ ROTR19 ^ SHR10
module sha256_sigma (
  input  logic [31:0] s0_in,
  input  logic [31:0] s1_in,
  output logic [31:0] s0_out,
  output logic [31:0] s1_out
);
  import sha256_pkg::*;

  always_comb begin
    s0_out = sha256_s0(s0_in);
    s1_out = sha256_s1(s1_in);
  end

endmodule

// File: rtl/sha256_w_schedule.sv
// SHA-256 message-schedule source. On start, reads one 16-word block from
// message memory, then streams W[0..63] for 64 consecutive cycles with the
// K-memory read port driven one cycle ahead so K[t] lands alongside W[t].
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   bus    sha256_w_schedule_if.master (memories, start, W stream, status)
// All interface outputs are registered and reset to 0.
module sha256_w_schedule #(
  parameter int unsigned MSG_ADDR_WIDTH  = 4,
  parameter int unsigned KMEM_ADDR_WIDTH = 6,
  parameter int unsigned ROUNDS          = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  sha256_w_schedule_if.master        bus
);
  import sha256_pkg::*;

  localparam int unsigned BLK_WIDTH = (MSG_ADDR_WIDTH > 4) ? MSG_ADDR_WIDTH - 4 : 1;
  localparam logic [5:0]  LAST_T    = 6'(ROUNDS - 1);
  localparam logic [5:0]  LAST_K    = 6'(MSG_WORDS - 1);

  sched_state_e          state_q, state_n;
  logic [5:0]            cnt_q, cnt_n;
  logic [BLK_WIDTH-1:0]  blk_q, blk_n;
  logic                  rd_pending_q;
  logic [31:0]           window_q [MSG_WORDS];
  logic [31:0]           s0_w, s1_w, w_new;
  logic [MSG_ADDR_WIDTH-1:0] addr_n;
  logic                  k_next_n;

  sha256_sigma u_sigma (
    .s0_in  (window_q[1]),
    .s1_in  (window_q[14]),
    .s0_out (s0_w),
    .s1_out (s1_w)
  );

  // window_q[0] holds W[t] during EMIT, so W[t+16] uses slots 14, 9, 1, 0.
  assign w_new = s1_w + window_q[9] + s0_w + window_q[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      blk_q   <= blk_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    blk_n   = blk_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_n = ST_FETCH;
          cnt_n   = '0;
          blk_n   = bus.msg_block;
        end
      end
      ST_FETCH: begin
        if (cnt_q == LAST_K) begin
          state_n = ST_DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 6'd1;
        end
      end
      ST_DRAIN: begin
        state_n = ST_EMIT;
        cnt_n   = '0;
      end
      ST_EMIT: begin
        if (cnt_q == LAST_T) begin
          state_n = ST_DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 6'd1;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe.
  always_comb begin
    addr_n   = MSG_ADDR_WIDTH'({blk_n, cnt_n[3:0]});
    k_next_n = (state_n == ST_EMIT) && (cnt_n != LAST_T);
  end

  // Captured words are shifted in at the tail rather than written to slot k;
  // after 16 captures slot k still holds word k, and EMIT reuses the same
  // shift. w_out takes slot 1 because the shift happens on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pending_q        <= 1'b0;
      for (int unsigned i = 0; i < MSG_WORDS; i++) window_q[i] <= '0;
      bus.msg_mem_enable  <= 1'b0;
      bus.msg_mem_address <= '0;
      bus.kmem_enable     <= 1'b0;
      bus.kmem_address    <= '0;
      bus.w_out           <= '0;
      bus.w_valid         <= 1'b0;
      bus.w_index         <= '0;
      bus.busy            <= 1'b0;
      bus.sched_done      <= 1'b0;
    end else begin
      // Read data trails the FETCH cycle that issued its address by one.
      rd_pending_q <= (state_q == ST_FETCH);

      if (rd_pending_q || (state_q == ST_EMIT)) begin
        for (int unsigned i = 0; i < MSG_WORDS - 1; i++) window_q[i] <= window_q[i+1];
        window_q[MSG_WORDS-1] <= rd_pending_q ? bus.msg_mem_data : w_new;
      end

      bus.msg_mem_enable  <= (state_n == ST_FETCH);
      bus.msg_mem_address <= (state_n == ST_FETCH) ? addr_n : '0;
      bus.kmem_enable     <= (state_n == ST_DRAIN) || k_next_n;
      bus.kmem_address    <= k_next_n ? KMEM_ADDR_WIDTH'(cnt_n + 6'd1) : '0;
      bus.w_valid         <= (state_n == ST_EMIT);
      bus.w_index         <= (state_n == ST_EMIT) ? cnt_n : '0;
      bus.w_out           <= (state_n == ST_EMIT) ? window_q[1] : '0;
      bus.busy            <= (state_n != ST_IDLE);
      bus.sched_done      <= (state_n == ST_DONE);
    end
  end

endmodule
